insn_encoder: RTL and testbench

INSN_ENCODER -- requirements
Module: insn_encoder

---
 rtl/insn_encoder.sv | 182 ++++++++++++++++++
 tb/tb_insn_encoder.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/insn_encoder.sv
// Encodes RV32I-style R/I/S/B instructions from field-level requests and
// buffers legal words in a small FIFO; illegal requests are dropped with an err pulse.
module insn_encoder #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  fmt,
    input  logic [1:0]  alu_op,
    input  logic        alt_op,
    input  logic [4:0]  ra,
    input  logic [4:0]  rb,
    input  logic [4:0]  rd,
    input  logic [31:0] imm,
    input  logic [2:0]  comparison,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_insn,
    output logic [15:0] count,
    output logic        err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OW = AW + 1;
    localparam logic [OW-1:0] DEPTH_C = OW'(DEPTH);
    localparam logic [OW-1:0] OCC_ONE = OW'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    localparam logic [1:0] FMT_R = 2'd0;
    localparam logic [1:0] FMT_I = 2'd1;
    localparam logic [1:0] FMT_S = 2'd2;
    localparam logic [1:0] FMT_B = 2'd3;

    localparam logic [6:0] OPC_R = 7'b0110011;
    localparam logic [6:0] OPC_I = 7'b0010011;
    localparam logic [6:0] OPC_S = 7'b0100011;
    localparam logic [6:0] OPC_B = 7'b1100011;

    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;
    localparam logic [2:0] FUNCT3_SW   = 3'b010;

    // alu_op selector to the funct3 shared by register and immediate forms
    function automatic logic [2:0] alu_funct3(input logic [1:0] op);
        logic [2:0] f3;
        case (op)
            2'd0:    f3 = 3'b000;
            2'd1:    f3 = 3'b111;
            2'd2:    f3 = 3'b110;
            2'd3:    f3 = 3'b100;
            default: f3 = 3'b000;
        endcase
        return f3;
    endfunction

    function automatic logic fits_simm12(input logic [31:0] v);
        return (v[31:12] == {20{v[11]}});
    endfunction

    // Branch offsets are 13-bit signed and must be halfword aligned
    function automatic logic fits_boff13(input logic [31:0] v);
        return (v[31:13] == {19{v[12]}}) && (v[0] == 1'b0);
    endfunction

    function automatic logic cmp_reserved(input logic [2:0] c);
        return (c == 3'b010) || (c == 3'b011);
    endfunction

    logic [31:0]   mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [OW-1:0] occ_r;
    logic          out_valid_r;
    logic [15:0]   count_r;
    logic          err_r;

    logic [31:0]   word_s;
    logic          illegal_s;
    logic          full_s;
    logic          accept_s;
    logic          push_s;
    logic          pop_s;
    logic [OW-1:0] occ_next_s;

    // Field packing and legality check for the request on the input port
    always_comb begin
        word_s    = 32'd0;
        illegal_s = 1'b0;
        case (fmt)
            FMT_R: begin
                word_s    = {(alt_op && (alu_op == 2'd0)) ? FUNCT7_ALT : FUNCT7_BASE,
                             rb, ra, alu_funct3(alu_op), rd, OPC_R};
                illegal_s = alt_op && (alu_op != 2'd0);
            end
            FMT_I: begin
                word_s    = {imm[11:0], ra, alu_funct3(alu_op), rd, OPC_I};
                illegal_s = !fits_simm12(imm);
            end
            FMT_S: begin
                word_s    = {imm[11:5], rb, ra, FUNCT3_SW, imm[4:0], OPC_S};
                illegal_s = !fits_simm12(imm);
            end
            FMT_B: begin
                word_s    = {imm[12], imm[10:5], rb, ra, comparison,
                             imm[4:1], imm[11], OPC_B};
                illegal_s = !fits_boff13(imm) || cmp_reserved(comparison);
            end
            default: begin
                word_s    = 32'd0;
                illegal_s = 1'b1;
            end
        endcase
    end

    assign full_s   = (occ_r == DEPTH_C);
    assign in_ready = !full_s && !flush;
    assign accept_s = in_valid && in_ready;
    assign push_s   = accept_s && !illegal_s;
    assign pop_s    = out_valid_r && out_ready && !flush;

    // Next occupancy; flush wins over any same-cycle push or pop
    always_comb begin
        occ_next_s = occ_r;
        if (flush) begin
            occ_next_s = '0;
        end else begin
            case ({push_s, pop_s})
                2'b10:   occ_next_s = occ_r + OCC_ONE;
                2'b01:   occ_next_s = occ_r - OCC_ONE;
                default: occ_next_s = occ_r;
            endcase
        end
    end

    // FIFO storage, written at the write pointer on every legal accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 32'd0;
            end
        end else if (push_s) begin
            mem_r[wr_ptr_r] <= word_s;
        end
    end

    // Pointer, occupancy, emitted-word counter and error pulse state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            occ_r       <= '0;
            out_valid_r <= 1'b0;
            count_r     <= 16'd0;
            err_r       <= 1'b0;
        end else begin
            occ_r       <= occ_next_s;
            out_valid_r <= (occ_next_s != '0);
            err_r       <= accept_s && illegal_s;
            if (flush) begin
                wr_ptr_r <= '0;
                rd_ptr_r <= '0;
            end else begin
                if (push_s) begin
                    wr_ptr_r <= wr_ptr_r + PTR_ONE;
                end
                if (pop_s) begin
                    rd_ptr_r <= rd_ptr_r + PTR_ONE;
                    count_r  <= count_r + 16'd1;
                end
            end
        end
    end

    assign out_valid = out_valid_r;
    assign out_insn  = mem_r[rd_ptr_r];
    assign count     = count_r;
    assign err       = err_r;

endmodule

// File: tb/tb_insn_encoder.sv
// Directed self-checking bench for insn_encoder: encodings, illegal requests,
// backpressure, concurrent push/pop, flush and asynchronous reset.
module tb_insn_encoder;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  fmt;
    logic [1:0]  alu_op;
    logic        alt_op;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [2:0]  comparison;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_insn;
    logic [15:0] count;
    logic        err;

    int          n_pass;
    int          n_total;
    logic [15:0] exp_count;

    insn_encoder #(.DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .fmt        (fmt),
        .alu_op     (alu_op),
        .alt_op     (alt_op),
        .ra         (ra),
        .rb         (rb),
        .rd         (rd),
        .imm        (imm),
        .comparison (comparison),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_insn   (out_insn),
        .count      (count),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic [1:0] f, input logic [1:0] op, input logic alt,
                             input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                             input logic [31:0] im, input logic [2:0] cmp);
        fmt = f; alu_op = op; alt_op = alt;
        ra = a; rb = b; rd = d; imm = im; comparison = cmp;
        in_valid = 1'b1;
    endtask

    task automatic send(input logic [1:0] f, input logic [1:0] op, input logic alt,
                        input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                        input logic [31:0] im, input logic [2:0] cmp);
        drive_req(f, op, alt, a, b, d, im, cmp);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        exp_count = exp_count + 16'd1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        fmt = 2'd0; alu_op = 2'd0; alt_op = 1'b0; ra = 5'd0; rb = 5'd0; rd = 5'd0;
        imm = 32'd0; comparison = 3'd0; exp_count = 16'd0;
        #2;
        n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else n_pass++;
        n_total++; if (count !== 16'd0) $display("FAIL reset_count got %h want 0000", count); else n_pass++;
        n_total++; if (err !== 1'b0) $display("FAIL reset_err got %b want 0", err); else n_pass++;
        #10 rst_n = 1'b1;
        #1;
        n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else n_pass++;
        tick();
    endtask

    task automatic test_r_encode();
        send(2'd0, 2'd0, 1'b1, 5'd2, 5'd3, 5'd1, 32'd0, 3'd0);
        n_total++; if (out_valid !== 1'b1) $display("FAIL r_sub_valid got %b want 1", out_valid); else n_pass++;
        n_total++; if (out_insn !== 32'h403100B3) $display("FAIL r_sub_word got %h want 403100B3", out_insn); else n_pass++;
        n_total++; if (err !== 1'b0) $display("FAIL r_sub_err got %b want 0", err); else n_pass++;
        pop_one();
        n_total++; if (count !== exp_count) $display("FAIL r_sub_count got %h want %h", count, exp_count); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL r_sub_drain got %b want 0", out_valid); else n_pass++;
        send(2'd0, 2'd3, 1'b0, 5'd5, 5'd6, 5'd4, 32'd0, 3'd0);
        n_total++; if (out_insn !== 32'h0062C233) $display("FAIL r_xor_word got %h want 0062C233", out_insn); else n_pass++;
        pop_one();
        send(2'd0, 2'd1, 1'b1, 5'd5, 5'd6, 5'd4, 32'd0, 3'd0);
        n_total++; if (err !== 1'b1) $display("FAIL r_alt_err got %b want 1", err); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL r_alt_noword got %b want 0", out_valid); else n_pass++;
        tick();
        n_total++; if (err !== 1'b0) $display("FAIL r_alt_err_pulse got %b want 0", err); else n_pass++;
    endtask

    task automatic test_i_encode();
        send(2'd1, 2'd0, 1'b0, 5'd0, 5'd0, 5'd5, 32'hFFFFFFFF, 3'd0);
        n_total++; if (out_insn !== 32'hFFF00293) $display("FAIL i_addi_word got %h want FFF00293", out_insn); else n_pass++;
        pop_one();
        send(2'd1, 2'd2, 1'b1, 5'd3, 5'd0, 5'd7, 32'h000007FF, 3'd0);
        n_total++; if (out_insn !== 32'h7FF1E393) $display("FAIL i_ori_word got %h want 7FF1E393", out_insn); else n_pass++;
        pop_one();
        send(2'd1, 2'd0, 1'b0, 5'd0, 5'd0, 5'd5, 32'h00000800, 3'd0);
        n_total++; if (err !== 1'b1) $display("FAIL i_range_err got %b want 1", err); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL i_range_noword got %b want 0", out_valid); else n_pass++;
        tick();
        n_total++; if (err !== 1'b0) $display("FAIL i_range_err_pulse got %b want 0", err); else n_pass++;
    endtask

    task automatic test_s_b_encode();
        send(2'd2, 2'd0, 1'b0, 5'd2, 5'd8, 5'd0, 32'hFFFFFFF8, 3'd0);
        n_total++; if (out_insn !== 32'hFE812C23) $display("FAIL s_sw_word got %h want FE812C23", out_insn); else n_pass++;
        pop_one();
        send(2'd3, 2'd0, 1'b1, 5'd1, 5'd2, 5'd0, 32'hFFFFFFFC, 3'b001);
        n_total++; if (out_insn !== 32'hFE209EE3) $display("FAIL b_bne_word got %h want FE209EE3", out_insn); else n_pass++;
        pop_one();
        n_total++; if (count !== exp_count) $display("FAIL b_count got %h want %h", count, exp_count); else n_pass++;
        send(2'd3, 2'd0, 1'b0, 5'd1, 5'd2, 5'd0, 32'h00000003, 3'b001);
        n_total++; if (err !== 1'b1) $display("FAIL b_odd_err got %b want 1", err); else n_pass++;
        tick();
        send(2'd3, 2'd0, 1'b0, 5'd1, 5'd2, 5'd0, 32'h00000004, 3'b010);
        n_total++; if (err !== 1'b1) $display("FAIL b_cmp_err got %b want 1", err); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL b_cmp_noword got %b want 0", out_valid); else n_pass++;
        tick();
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_words [4];
        exp_words[0] = 32'h00100093; exp_words[1] = 32'h00200113;
        exp_words[2] = 32'h00300193; exp_words[3] = 32'h00400213;
        out_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            send(2'd1, 2'd0, 1'b0, 5'd0, 5'd0, 5'(k), 32'(k), 3'd0);
            if (k == 3) begin
                n_total++; if (in_ready !== 1'b1) $display("FAIL bp_ready_3 got %b want 1", in_ready); else n_pass++;
            end
        end
        n_total++; if (in_ready !== 1'b0) $display("FAIL bp_full got %b want 0", in_ready); else n_pass++;
        send(2'd1, 2'd0, 1'b0, 5'd0, 5'd0, 5'd9, 32'd9, 3'd0);
        n_total++; if (err !== 1'b0) $display("FAIL bp_full_err got %b want 0", err); else n_pass++;
        n_total++; if (out_insn !== exp_words[0]) $display("FAIL bp_hold got %h want %h", out_insn, exp_words[0]); else n_pass++;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n_total++; if (out_insn !== exp_words[k]) $display("FAIL bp_order_%0d got %h want %h", k, out_insn, exp_words[k]); else n_pass++;
            tick();
            exp_count = exp_count + 16'd1;
        end
        out_ready = 1'b0;
        n_total++; if (out_valid !== 1'b0) $display("FAIL bp_empty got %b want 0", out_valid); else n_pass++;
        n_total++; if (count !== exp_count) $display("FAIL bp_count got %h want %h", count, exp_count); else n_pass++;
    endtask

    task automatic test_back_to_back();
        send(2'd1, 2'd0, 1'b0, 5'd0, 5'd0, 5'd1, 32'd1, 3'd0);
        drive_req(2'd1, 2'd0, 1'b0, 5'd0, 5'd0, 5'd2, 32'd2, 3'd0);
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        exp_count = exp_count + 16'd1;
        n_total++; if (out_valid !== 1'b1) $display("FAIL b2b_valid got %b want 1", out_valid); else n_pass++;
        n_total++; if (out_insn !== 32'h00200113) $display("FAIL b2b_head got %h want 00200113", out_insn); else n_pass++;
        n_total++; if (count !== exp_count) $display("FAIL b2b_count got %h want %h", count, exp_count); else n_pass++;
        pop_one();
        n_total++; if (out_valid !== 1'b0) $display("FAIL b2b_drain got %b want 0", out_valid); else n_pass++;
    endtask

    task automatic test_flush();
        send(2'd1, 2'd0, 1'b0, 5'd0, 5'd0, 5'd1, 32'd1, 3'd0);
        send(2'd1, 2'd0, 1'b0, 5'd0, 5'd0, 5'd2, 32'd2, 3'd0);
        flush = 1'b1; out_ready = 1'b1;
        drive_req(2'd1, 2'd0, 1'b0, 5'd0, 5'd0, 5'd5, 32'h00000800, 3'd0);
        #1;
        n_total++; if (in_ready !== 1'b0) $display("FAIL flush_in_ready got %b want 0", in_ready); else n_pass++;
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        n_total++; if (out_valid !== 1'b0) $display("FAIL flush_valid got %b want 0", out_valid); else n_pass++;
        n_total++; if (count !== exp_count) $display("FAIL flush_count got %h want %h", count, exp_count); else n_pass++;
        n_total++; if (err !== 1'b0) $display("FAIL flush_err got %b want 0", err); else n_pass++;
        tick();
        n_total++; if (out_valid !== 1'b0) $display("FAIL flush_stays_empty got %b want 0", out_valid); else n_pass++;
    endtask

    task automatic test_async_reset();
        send(2'd1, 2'd0, 1'b0, 5'd0, 5'd0, 5'd3, 32'd3, 3'd0);
        send(2'd1, 2'd0, 1'b0, 5'd0, 5'd0, 5'd4, 32'd4, 3'd0);
        pop_one();
        n_total++; if (count !== exp_count) $display("FAIL arst_precount got %h want %h", count, exp_count); else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        exp_count = 16'd0;
        n_total++; if (count !== exp_count) $display("FAIL arst_count got %h want 0000", count); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL arst_valid got %b want 0", out_valid); else n_pass++;
        #3 rst_n = 1'b1;
        tick();
        tick();
        n_total++; if (out_valid !== 1'b0) $display("FAIL arst_no_replay got %b want 0", out_valid); else n_pass++;
        n_total++; if (in_ready !== 1'b1) $display("FAIL arst_in_ready got %b want 1", in_ready); else n_pass++;
        send(2'd0, 2'd0, 1'b1, 5'd2, 5'd3, 5'd1, 32'd0, 3'd0);
        n_total++; if (out_insn !== 32'h403100B3) $display("FAIL arst_resume got %h want 403100B3", out_insn); else n_pass++;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_r_encode();
        test_i_encode();
        test_s_b_encode();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
